// File: rtl/amber48_dmem_responder.sv
// Data-memory responder for the amber48 core. It adds a fixed number of wait states,
// traps misaligned or out-of-range accesses, and has a backdoor port for preloading memory.
module amber48_dmem_responder #(
    parameter int unsigned     XLEN        = 48,
    parameter int unsigned     BAU_BYTES   = 6,
    parameter int unsigned     DEPTH       = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int unsigned     WAIT_CYCLES = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clk_en_i,
    input  logic                     dmem_req_i,
    input  logic                     dmem_we_i,
    input  logic [XLEN-1:0]          dmem_addr_i,
    input  logic [XLEN-1:0]          dmem_wdata_i,
    output logic [XLEN-1:0]          dmem_rdata_o,
    output logic                     dmem_ready_o,
    output logic                     dmem_trap_o,
    input  logic                     bd_we_i,
    input  logic [$clog2(DEPTH)-1:0] bd_idx_i,
    input  logic [XLEN-1:0]          bd_wdata_i,
    output logic                     proto_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            proto_err_q, proto_err_d;

    logic [XLEN-1:0] mem [DEPTH];

    logic             borrow;
    logic [XLEN-1:0]  offset;
    logic [XLEN-1:0]  quot;
    logic [XLEN-1:0]  rem;
    logic             fault;
    logic [IDX_W-1:0] idx;
    logic             same_req;
    logic             complete;
    logic             bd_ok;

    // The borrow out of the subtraction flags addresses below BASE_ADDR.
    assign {borrow, offset} = {1'b0, dmem_addr_i} - {1'b0, BASE_ADDR};
    assign quot  = offset / XLEN'(BAU_BYTES);
    assign rem   = offset % XLEN'(BAU_BYTES);
    assign fault = borrow || (rem != '0) || (quot >= XLEN'(DEPTH));
    assign idx   = quot[IDX_W-1:0];

    assign same_req = dmem_req_i && (dmem_we_i == we_q) && (dmem_addr_i == addr_q);

    if (DEPTH == (1 << IDX_W)) begin : g_bd_pow2
        assign bd_ok = 1'b1;
    end else begin : g_bd_range
        assign bd_ok = (32'(bd_idx_i) < DEPTH);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        proto_err_d = proto_err_q;
        complete    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dmem_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        we_d    = dmem_we_i;
                        addr_d  = dmem_addr_i;
                        cnt_d   = 4'd1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!same_req) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    proto_err_d = 1'b1;
                end else if (cnt_q == 4'(WAIT_CYCLES)) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A request never completes while held in reset or stalled.
        if (!rst_ni || !clk_en_i) begin
            complete = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
        end else if (clk_en_i) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            proto_err_q <= proto_err_d;
        end
    end

    // The core store is assigned last, so it wins over a backdoor write to the same word.
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if (bd_we_i && bd_ok) begin
                mem[bd_idx_i] <= bd_wdata_i;
            end
            if (complete && dmem_we_i && !fault) begin
                mem[idx] <= dmem_wdata_i;
            end
        end
    end

    assign dmem_ready_o = complete;
    assign dmem_trap_o  = complete && fault;
    assign dmem_rdata_o = (complete && !fault && !dmem_we_i) ? mem[idx] : '0;
    assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_amber48_dmem_responder.sv
// Bench for amber48_dmem_responder. It runs directed sequences and a vector table on a
// zero-wait instance, then compares random traffic against a word-array memory model.
module tb_amber48_dmem_responder;

    localparam int WAITC = 2;

    logic        clk;
    logic        rst_n;
    logic        en, req, we, bd_we;
    logic [47:0] addr, wdata, bd_wdata, rdata;
    logic [9:0]  bd_idx;
    logic        ready, trap, perr;

    logic        en0, req0, we0, bd_we0;
    logic [47:0] addr0, wdata0, bd_wdata0, rdata0;
    logic [9:0]  bd_idx0;
    logic        ready0, trap0, perr0;

    int checks = 0;
    int failures = 0;
    logic [47:0] model [1024];

    amber48_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(WAITC)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clk_en_i(en), .dmem_req_i(req), .dmem_we_i(we),
        .dmem_addr_i(addr), .dmem_wdata_i(wdata), .dmem_rdata_o(rdata),
        .dmem_ready_o(ready), .dmem_trap_o(trap), .bd_we_i(bd_we), .bd_idx_i(bd_idx),
        .bd_wdata_i(bd_wdata), .proto_err_o(perr)
    );

    amber48_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clk_en_i(en0), .dmem_req_i(req0), .dmem_we_i(we0),
        .dmem_addr_i(addr0), .dmem_wdata_i(wdata0), .dmem_rdata_o(rdata0),
        .dmem_ready_o(ready0), .dmem_trap_o(trap0), .bd_we_i(bd_we0), .bd_idx_i(bd_idx0),
        .bd_wdata_i(bd_wdata0), .proto_err_o(perr0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          en;
        bit          req;
        bit          we;
        logic [47:0] addr;
        logic [47:0] wdata;
        bit          rdy;
        bit          trp;
        logic [47:0] rdata;
    } vec_t;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[47:0];
    endfunction

    function automatic logic [47:0] rand_addr();
        logic [47:0] r;
        case ($urandom_range(0, 9))
            0: r = 48'(6 * $urandom_range(0, 15) + $urandom_range(1, 5));
            1: r = 48'(6 * (1024 + $urandom_range(0, 3)));
            2: r = rand48();
            default: r = 48'(6 * $urandom_range(0, 15));
        endcase
        return r;
    endfunction

    // Idle cycles with req low; random stalls and backdoor writes when rnd is set.
    task automatic idle(input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            req      = 1'b0;
            en       = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bd_we    = rnd && ($urandom_range(0, 1) == 0);
            bd_idx   = 10'($urandom_range(0, 15));
            bd_wdata = rand48();
            #1;
            check("idle_ready", 48'(ready), 48'(0));
            check("idle_trap", 48'(trap), 48'(0));
            check("idle_rdata", rdata, 48'(0));
            if (en && bd_we) model[bd_idx] = bd_wdata;
            tick();
        end
        en    = 1'b1;
        bd_we = 1'b0;
    endtask

    // One request held until it completes: ready is due on the (WAITC+1)th enabled cycle.
    task automatic txn(input bit we_v, input logic [47:0] a, input logic [47:0] wd,
                       input bit rnd, output logic [47:0] seen);
        longint unsigned la;
        bit              flt;
        int unsigned     idx;
        int              en_cnt;
        bit              exp_rdy;
        logic [47:0]     exp_rd;
        la   = a;
        flt  = ((la % 6) != 0) || ((la / 6) >= 1024);
        idx  = flt ? 0 : int'(la / 6);
        seen = '0;
        en_cnt = 0;
        req   = 1'b1;
        we    = we_v;
        addr  = a;
        wdata = wd;
        for (int c = 0; c < 40 && en_cnt <= WAITC; c++) begin
            en       = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bd_we    = rnd && ($urandom_range(0, 2) == 0);
            bd_idx   = 10'($urandom_range(0, 15));
            bd_wdata = rand48();
            #1;
            exp_rdy = en && (en_cnt == WAITC);
            exp_rd  = (exp_rdy && !flt && !we_v) ? model[idx] : '0;
            check("txn_ready", 48'(ready), 48'(exp_rdy));
            check("txn_trap", 48'(trap), 48'(exp_rdy && flt));
            check("txn_rdata", rdata, exp_rd);
            if (ready) seen = rdata;
            if (en) begin
                if (bd_we) model[bd_idx] = bd_wdata;
                if (exp_rdy && !flt && we_v) model[idx] = wd;
                en_cnt++;
            end
            tick();
        end
        check("txn_done", 48'(en_cnt), 48'(WAITC + 1));
        en    = 1'b1;
        bd_we = 1'b0;
    endtask

    initial begin
        logic [47:0] seen;
        logic [47:0] p0 [3];
        vec_t        vecs [11];

        p0[0] = 48'h1111_1111_1111;
        p0[1] = 48'h222;
        p0[2] = 48'h333;
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 48'd0,    48'd0,      1'b1, 1'b0, 48'h1111_1111_1111};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 48'd0,    48'd0,      1'b0, 1'b0, 48'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 48'd6,    48'd0,      1'b1, 1'b0, 48'h222};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 48'd12,   48'd0,      1'b1, 1'b0, 48'h333};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 48'd12,   48'hBEEF,   1'b1, 1'b0, 48'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 48'd12,   48'd0,      1'b1, 1'b0, 48'hBEEF};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 48'd13,   48'd0,      1'b1, 1'b1, 48'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 48'd6144, 48'h5A,     1'b1, 1'b1, 48'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 48'd0,    48'd0,      1'b1, 1'b0, 48'h1111_1111_1111};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 48'd6,    48'd0,      1'b0, 1'b0, 48'd0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 48'd6,    48'd0,      1'b1, 1'b0, 48'h222};

        clk = 1'b0;
        rst_n = 1'b0;
        en = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        bd_we = 1'b0; bd_idx = '0; bd_wdata = '0;
        en0 = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        bd_we0 = 1'b0; bd_idx0 = '0; bd_wdata0 = '0;

        // Outputs must read zero while reset is held, even with a request pending.
        tick();
        tick();
        check("rst_ready", 48'(ready), 48'(0));
        check("rst_ready0", 48'(ready0), 48'(0));
        check("rst_trap0", 48'(trap0), 48'(0));
        check("rst_rdata0", rdata0, 48'(0));
        rst_n = 1'b1;
        req = 1'b0;
        req0 = 1'b0;
        #1;
        check("rst_perr", 48'(perr), 48'(0));
        check("rst_perr0", 48'(perr0), 48'(0));
        tick();

        for (int i = 0; i < 16; i++) begin
            bd_we = 1'b1;
            bd_idx = 10'(i);
            bd_wdata = rand48();
            model[i] = bd_wdata;
            bd_we0 = (i < 3);
            bd_idx0 = 10'(i);
            bd_wdata0 = (i < 3) ? p0[i] : '0;
            tick();
        end
        bd_we = 1'b0;
        bd_we0 = 1'b0;

        // Preloaded word comes back on the second wait cycle.
        bd_we = 1'b1; bd_idx = 10'd5; bd_wdata = 48'hABCDEF;
        model[5] = 48'hABCDEF;
        tick();
        bd_we = 1'b0;
        txn(1'b0, 48'd30, 48'd0, 1'b0, seen);
        check("load30_rdata", seen, 48'hABCDEF);
        idle(1, 1'b0);

        // Store, then load the same word back-to-back.
        txn(1'b1, 48'd12, 48'h123, 1'b0, seen);
        txn(1'b0, 48'd12, 48'd0, 1'b0, seen);
        check("store_load12", seen, 48'h123);

        // Faulting accesses; the following load of word 0 confirms nothing was written.
        txn(1'b0, 48'd31, 48'd0, 1'b0, seen);
        check("misalign_rdata", seen, 48'd0);
        txn(1'b1, 48'd6144, 48'h77, 1'b0, seen);
        txn(1'b0, 48'd0, 48'd0, 1'b0, seen);
        idle(1, 1'b0);

        // Zero-wait instance, one vector per cycle.
        for (int i = 0; i < 11; i++) begin
            en0 = vecs[i].en; req0 = vecs[i].req; we0 = vecs[i].we;
            addr0 = vecs[i].addr; wdata0 = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_ready", i), 48'(ready0), 48'(vecs[i].rdy));
            check($sformatf("vec%0d_trap", i), 48'(trap0), 48'(vecs[i].trp));
            check($sformatf("vec%0d_rdata", i), rdata0, vecs[i].rdata);
            tick();
        end
        req0 = 1'b0;
        en0 = 1'b1;

        // Two stalled cycles after the first request cycle push ready back by two.
        req = 1'b1; we = 1'b0; addr = 48'd30;
        for (int c = 0; c < 5; c++) begin
            en = (c != 1) && (c != 2);
            #1;
            check($sformatf("stall_c%0d_ready", c), 48'(ready), 48'(c == 4));
            if (c == 4) check("stall_rdata", rdata, model[5]);
            tick();
        end
        en = 1'b1;
        idle(1, 1'b0);

        repeat (150) begin
            idle($urandom_range(0, 2), 1'b1);
            txn($urandom_range(0, 1) == 1, rand_addr(), rand48(), 1'b1, seen);
        end
        idle(1, 1'b0);

        // Dropping req mid-wait aborts and sets the sticky error.
        check("perr_before_abort", 48'(perr), 48'(0));
        req = 1'b1; we = 1'b0; addr = 48'd0;
        #1;
        check("abort_c0_ready", 48'(ready), 48'(0));
        tick();
        check("abort_c1_ready", 48'(ready), 48'(0));
        tick();
        req = 1'b0;
        #1;
        check("abort_c2_ready", 48'(ready), 48'(0));
        tick();
        check("abort_perr", 48'(perr), 48'(1));
        idle(2, 1'b0);
        check("abort_perr_sticky", 48'(perr), 48'(1));
        txn(1'b0, 48'd6, 48'd0, 1'b0, seen);
        check("after_abort_rdata", seen, model[1]);
        check("abort_perr_sticky2", 48'(perr), 48'(1));

        // Reset on the would-be ready cycle of a store: no ready, word unchanged.
        req = 1'b1; we = 1'b1; addr = 48'd18; wdata = 48'hDEAD_BEEF;
        #1;
        check("rststore_c0_ready", 48'(ready), 48'(0));
        tick();
        check("rststore_c1_ready", 48'(ready), 48'(0));
        tick();
        rst_n = 1'b0;
        #1;
        check("rststore_c2_ready", 48'(ready), 48'(0));
        check("rststore_c2_trap", 48'(trap), 48'(0));
        tick();
        rst_n = 1'b1;
        req = 1'b0;
        #1;
        check("rststore_perr", 48'(perr), 48'(0));
        tick();
        txn(1'b0, 48'd18, 48'd0, 1'b0, seen);
        check("rststore_word", seen, model[3]);
        idle(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/amber48_dmem_responder.md
AMBER48_DMEM_RESPONDER -- requirements
Module: amber48_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of XLEN-bit storage words.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning extra cycles before dmem_ready_o.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_ni, input, 1, reset; it is synchronous and active-low.
REQ-006 SHALL have port clk_en_i, input, 1, global clock enable matching the core's.
REQ-007 SHALL have port dmem_req_i, input, 1, request valid from core.
REQ-008 SHALL have port dmem_we_i, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port dmem_addr_i, input, XLEN, byte address.
REQ-010 SHALL have port dmem_wdata_i, input, XLEN, store data.
REQ-011 SHALL have port dmem_rdata_o, output, XLEN, load data.
REQ-012 SHALL have port dmem_ready_o, output, 1, request completes this cycle.
REQ-013 SHALL have port dmem_trap_o, output, 1, fault qualifier, meaningful only with dmem_ready_o.
REQ-014 SHALL have port bd_we_i, input, 1, backdoor preload write strobe.
REQ-015 SHALL have port bd_idx_i, input, $clog2(DEPTH), backdoor word index.
REQ-016 SHALL have port bd_wdata_i, input, XLEN, backdoor write data.
REQ-017 SHALL have port proto_err_o, output, 1, sticky protocol-violation flag.

Function
REQ-018 SHALL decode the word index as (dmem_addr_i - BASE_ADDR) / BAU_BYTES, using constant division with the remainder kept.
REQ-019 SHALL declare a fault when the remainder is nonzero, when dmem_addr_i < BASE_ADDR, or when the index is >= DEPTH.
REQ-020 SHALL implement the FSM states IDLE and WAIT, plus a 4-bit wait counter.
REQ-021 IDLE: with dmem_req_i=1 and WAIT_CYCLES=0, SHALL assert dmem_ready_o combinationally in the same cycle and stay in IDLE.
REQ-022 IDLE: with dmem_req_i=1 and WAIT_CYCLES>0, SHALL latch we and addr, set counter=1, and go to WAIT; ready=0 that cycle.
REQ-023 WAIT: SHALL assert dmem_ready_o when counter==WAIT_CYCLES and the request is unchanged, then return to IDLE; otherwise it increments the counter.
REQ-024 Latency: SHALL assert ready exactly WAIT_CYCLES cycles after the first req cycle, held high for exactly one cycle per request.
REQ-025 SHALL treat dmem_req_i=1 in the cycle after ready as a new request, with no idle bubble required.
REQ-026 SHALL treat dmem_req_i falling, or we/addr changing, while in WAIT as an abort: return to IDLE without ready or write, and set proto_err_o.
REQ-027 SHALL clear proto_err_o only by reset.
REQ-028 Load, no fault: SHALL drive dmem_rdata_o = mem[index] with asynchronous read in the ready cycle, and 0 in every other cycle.
REQ-029 Store, no fault: SHALL write mem[index] <= dmem_wdata_i at the clock edge ending the ready cycle, exactly once.
REQ-030 Fault: SHALL assert dmem_ready_o and dmem_trap_o together, drive rdata 0, and perform no write.
REQ-031 SHALL hold dmem_trap_o at 0 whenever dmem_ready_o is 0.
REQ-032 SHALL perform a backdoor write of mem[bd_idx_i] <= bd_wdata_i on any enabled edge with bd_we_i=1, ignoring an out-of-range bd_idx_i.
REQ-033 When a backdoor write and a core store hit the same index on the same edge, SHALL let the core store win.
REQ-034 When clk_en_i=0, SHALL freeze state, counter, memory and proto_err_o, and force dmem_ready_o and dmem_trap_o to 0.
REQ-035 SHALL return a store's value on a load issued in the cycle immediately after that store's ready cycle.

Reset
REQ-036 With rst_ni=0 at a clk_i edge, SHALL set state=IDLE, counter=0, proto_err_o=0; dmem_ready_o, dmem_trap_o and dmem_rdata_o read 0 during reset.
REQ-037 SHALL leave memory contents unchanged by reset.
REQ-038 SHALL abandon any in-flight request on reset, with no ready and no write.

Verification (XLEN=48, BAU_BYTES=6, BASE_ADDR=0, DEPTH=1024, WAIT_CYCLES=2 unless noted)
REQ-039 Backdoor mem[5]=0xABCDEF; load addr 30 held -> ready in cycle 2 only, rdata=0xABCDEF, trap=0.
REQ-040 Store 0x123 to addr 12, then load addr 12 the next cycle -> second ready shows rdata=0x123; mem[2] written once.
REQ-041 Load addr 31 (misaligned), and store addr 6144 (index 1024) -> each gets ready+trap, rdata=0, no memory change.
REQ-042 WAIT_CYCLES=0: back-to-back req to addrs 0, 6, 12 -> ready=1 every cycle, data mem[0], mem[1], mem[2].
REQ-043 Drop req after 1 WAIT cycle -> no ready, proto_err_o=1 sticky; the next full request completes normally.
REQ-044 Assert rst_ni=0 mid-WAIT during a store -> no ready, target word unchanged; hold clk_en_i=0 two cycles mid-WAIT -> ready delayed by exactly 2 cycles.
